// File: rtl/pcpi_result_serializer_if.sv
// Coprocessor-result capture and host nibble-handshake signals of the result serialiser.
interface pcpi_result_serializer_if #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
);
  logic              pcpi_ready;
  logic              pcpi_wr;
  logic [DATA_W-1:0] pcpi_rd;
  logic              nib_ack;
  logic [NIB_W-1:0]  nib_out;
  logic              nib_valid;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output pcpi_ready, pcpi_wr, pcpi_rd, nib_ack,
    input  nib_out, nib_valid, busy, done, ovf
  );

  modport slave (
    input  pcpi_ready, pcpi_wr, pcpi_rd, nib_ack,
    output nib_out, nib_valid, busy, done, ovf
  );
endinterface

// File: rtl/pcpi_result_serializer.sv
// Captures a PCPI writeback result and returns it LSB nibble first over a four-phase valid/ack link.
// First nibble valid 1 cycle after capture; results arriving while busy are dropped and flagged in ovf.
module pcpi_result_serializer #(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pcpi_result_serializer_if.slave bus
);
  localparam int NNIB  = DATA_W / NIB_W;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  typedef enum logic [1:0] {IDLE, ARM, PRESENT, WAIT_LOW} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [IDX_W-1:0]  idx;
  logic              ack_m;
  logic              ack_s;
  logic [NIB_W-1:0]  nib_out_q;
  logic              nib_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic              strobe;

  assign strobe    = bus.pcpi_ready && bus.pcpi_wr;
  assign shreg_nxt = shreg >> NIB_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      idx         <= '0;
      ack_m       <= 1'b0;
      ack_s       <= 1'b0;
      nib_out_q   <= '0;
      nib_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ack_m  <= bus.nib_ack;
      ack_s  <= ack_m;
      done_q <= 1'b0;

      if (strobe && state != IDLE)
        ovf_q <= 1'b1;

      case (state)
        IDLE: begin
          if (strobe) begin
            shreg     <= bus.pcpi_rd;
            idx       <= '0;
            nib_out_q <= bus.pcpi_rd[NIB_W-1:0];
            busy_q    <= 1'b1;
            // A host still holding ack high must release it before the first nibble
            if (ack_s) begin
              state <= ARM;
            end else begin
              state       <= PRESENT;
              nib_valid_q <= 1'b1;
            end
          end
        end
        ARM: begin
          if (!ack_s) begin
            state       <= PRESENT;
            nib_valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (ack_s) begin
            state       <= WAIT_LOW;
            nib_valid_q <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (!ack_s) begin
            if (idx != LAST_IDX) begin
              shreg       <= shreg_nxt;
              nib_out_q   <= shreg_nxt[NIB_W-1:0];
              idx         <= idx + IDX_W'(1);
              state       <= PRESENT;
              nib_valid_q <= 1'b1;
            end else begin
              idx    <= '0;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          nib_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nib_out   = nib_out_q;
  assign bus.nib_valid = nib_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pcpi_result_serializer.sv
// Directed bench for pcpi_result_serializer: vector table of results plus reset/strobe corner sequences.
module tb_pcpi_result_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcpi_result_serializer_if #(.DATA_W(32), .NIB_W(4)) ifc ();

  pcpi_result_serializer #(.DATA_W(32), .NIB_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // exp_seq lists the expected nibbles in transmission order, first nibble in the top hex digit
  typedef struct {
    logic [31:0] rd;
    bit          stale;
    int          inject;
    logic [31:0] exp_seq;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (ifc.done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input logic lvl, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifc.nib_valid === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic capture(input logic [31:0] rd, input bit stale, input logic [3:0] first);
    @(negedge clk);
    ifc.pcpi_rd    = rd;
    ifc.pcpi_ready = 1'b1;
    ifc.pcpi_wr    = 1'b1;
    @(negedge clk);
    ifc.pcpi_ready = 1'b0;
    ifc.pcpi_wr    = 1'b0;
    chk("busy_after_capture", 32'(ifc.busy), 32'd1);
    if (!stale) begin
      chk("first_latency_valid", 32'(ifc.nib_valid), 32'd1);
      chk("first_latency_nib", 32'(ifc.nib_out), 32'(first));
    end
  endtask

  // Plays the host side; stop_at >= 0 returns as soon as that nibble index is presented
  task automatic serialize(input logic [31:0] seq, input int inject, input int stop_at);
    int d0 = done_cnt;
    bit got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] e = seq[31-4*i -: 4];
      wait_valid(1'b1, "wait_valid_high");
      chk($sformatf("nib%0d", i), 32'(ifc.nib_out), 32'(e));
      if (i == stop_at) return;
      if (i == inject) begin
        ifc.pcpi_rd    = 32'hFFFF_FFFF;
        ifc.pcpi_ready = 1'b1;
        ifc.pcpi_wr    = 1'b1;
        @(negedge clk);
        ifc.pcpi_ready = 1'b0;
        ifc.pcpi_wr    = 1'b0;
        chk("nib_during_drop", 32'(ifc.nib_out), 32'(e));
      end
      ifc.nib_ack = 1'b1;
      wait_valid(1'b0, "wait_valid_low");
      chk($sformatf("hold%0d", i), 32'(ifc.nib_out), 32'(e));
      ifc.nib_ack = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("busy_idle", 32'(ifc.busy), 32'd0);
    chk("valid_idle", 32'(ifc.nib_valid), 32'd0);
  endtask

  task automatic run_vec(input int k);
    capture(vecs[k].rd, vecs[k].stale, vecs[k].exp_seq[31:28]);
    if (vecs[k].stale) begin
      bit seen = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (ifc.nib_valid !== 1'b0) seen = 1'b1;
      end
      chk("arm_valid_low", 32'(seen), 32'd0);
      chk("arm_busy", 32'(ifc.busy), 32'd1);
      ifc.nib_ack = 1'b0;
    end
    serialize(vecs[k].exp_seq, vecs[k].inject, -1);
    chk($sformatf("ovf_vec%0d", k), 32'(ifc.ovf), 32'(vecs[k].exp_ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_nib_out"}, 32'(ifc.nib_out), 32'd0);
    chk({tag, "_valid"}, 32'(ifc.nib_valid), 32'd0);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
    chk({tag, "_done"}, 32'(ifc.done), 32'd0);
    chk({tag, "_ovf"}, 32'(ifc.ovf), 32'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{32'h1234_ABCD, 1'b0, -1, 32'hDCBA_4321, 1'b0};
    vecs[1] = '{32'h1234_ABCD, 1'b1, -1, 32'hDCBA_4321, 1'b0};
    vecs[2] = '{32'h1234_ABCD, 1'b0,  3, 32'hDCBA_4321, 1'b1};
    vecs[3] = '{32'h0F1E_2D3C, 1'b0, -1, 32'hC3D2_E1F0, 1'b1};
    vecs[4] = '{32'h0000_0005, 1'b0, -1, 32'h5000_0000, 1'b0};

    // Reset with random inputs
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      ifc.pcpi_ready = 1'($urandom);
      ifc.pcpi_wr    = 1'($urandom);
      ifc.pcpi_rd    = $urandom;
      ifc.nib_ack    = 1'($urandom);
    end
    @(negedge clk);
    chk_zero("reset");
    ifc.pcpi_ready = 1'b0;
    ifc.pcpi_wr    = 1'b0;
    ifc.nib_ack    = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Unqualified strobe is ignored
    ifc.pcpi_rd    = 32'hDEAD_BEEF;
    ifc.pcpi_ready = 1'b1;
    ifc.pcpi_wr    = 1'b0;
    @(negedge clk);
    ifc.pcpi_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("unqual_busy", 32'(ifc.busy), 32'd0);
    chk("unqual_valid", 32'(ifc.nib_valid), 32'd0);

    // Basic, stale-ack and overflow vectors; ack is raised early for the stale case
    for (int k = 0; k < 4; k++) begin
      if (vecs[k].stale) begin
        ifc.nib_ack = 1'b1;
        repeat (4) @(negedge clk);
      end
      run_vec(k);
      repeat (2) @(negedge clk);
    end

    // Reset while nibble index 3 is presented
    d0 = done_cnt;
    capture(32'h1234_ABCD, 1'b0, 4'hD);
    serialize(32'hDCBA_4321, -1, 3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midreset_busy", 32'(ifc.busy), 32'd0);

    run_vec(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
